// File: rtl/ysyx_040729_exe_mdu_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer.
package ysyx_040729_exe_mdu_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_ISSUE = 3'd1,
        ST_MUL_WAIT  = 3'd2,
        ST_DIV_ISSUE = 3'd3,
        ST_DIV_WAIT  = 3'd4,
        ST_DONE      = 3'd5
    } mdu_state_e;

    // RV64M func3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ysyx_040729_exe_mdu_fixup.sv
// Combinational operand preparation, divide special-case detection and
// result fix-up for the multiply/divide sequencer.
module ysyx_040729_exe_mdu_fixup
    import ysyx_040729_exe_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [2:0]              req_func3,
    input  logic                    req_word,
    input  logic [DATA_WIDTH-1:0]   req_src1,
    input  logic [DATA_WIDTH-1:0]   req_src2,
    output logic [DATA_WIDTH-1:0]   prep_a_c,
    output logic [DATA_WIDTH-1:0]   prep_b_c,
    output logic [1:0]              mul_signed_c,
    output logic                    neg_q_c,
    output logic                    neg_r_c,
    output logic                    special_c,
    output logic [DATA_WIDTH-1:0]   special_data_c,
    input  logic [2:0]              op_func3,
    input  logic                    op_word,
    input  logic                    op_neg_q,
    input  logic                    op_neg_r,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    input  logic [DATA_WIDTH-1:0]   div_quo,
    input  logic [DATA_WIDTH-1:0]   div_rem,
    output logic [DATA_WIDTH-1:0]   fix_data_c
);

    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam logic [DATA_WIDTH-1:0] MIN_FULL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [HW-1:0]         MIN_HALF = {1'b1, {(HW-1){1'b0}}};

    function automatic logic [DATA_WIDTH-1:0] sext_half(input logic [DATA_WIDTH-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    logic [DATA_WIDTH-1:0] a_ext;
    logic [DATA_WIDTH-1:0] b_ext;
    logic                  ext_signed;
    logic                  div_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] spec_raw;

    // Request-side prep: W extension, magnitudes, special cases
    always_comb begin
        ext_signed = !(req_func3[2] && req_func3[0]);
        a_ext      = req_src1;
        b_ext      = req_src2;
        if (req_word) begin
            a_ext = ext_signed ? {{HW{req_src1[HW-1]}}, req_src1[HW-1:0]}
                               : {{HW{1'b0}}, req_src1[HW-1:0]};
            b_ext = ext_signed ? {{HW{req_src2[HW-1]}}, req_src2[HW-1:0]}
                               : {{HW{1'b0}}, req_src2[HW-1:0]};
        end

        div_signed = req_func3[2] && !req_func3[0];
        a_neg      = div_signed && a_ext[DATA_WIDTH-1];
        b_neg      = div_signed && b_ext[DATA_WIDTH-1];
        neg_q_c    = a_neg ^ b_neg;
        neg_r_c    = a_neg;

        if (req_func3[2]) begin
            prep_a_c = a_neg ? -a_ext : a_ext;
            prep_b_c = b_neg ? -b_ext : b_ext;
        end else begin
            prep_a_c = a_ext;
            prep_b_c = b_ext;
        end

        unique case (req_func3)
            F3_MUL, F3_MULH: mul_signed_c = 2'b11;
            F3_MULHSU:       mul_signed_c = 2'b10;
            default:         mul_signed_c = 2'b00;
        endcase

        div_zero = (b_ext == '0);
        if (req_word) begin
            overflow = div_signed && (a_ext[HW-1:0] == MIN_HALF) && (b_ext[HW-1:0] == '1);
        end else begin
            overflow = div_signed && (a_ext == MIN_FULL) && (b_ext == '1);
        end
        special_c = req_func3[2] && (div_zero || overflow);

        if (div_zero) begin
            spec_raw = req_func3[1] ? a_ext : '1;
        end else begin
            spec_raw = req_func3[1] ? '0 : a_ext;
        end
        special_data_c = req_word ? sext_half(spec_raw) : spec_raw;
    end

    logic [DATA_WIDTH-1:0] mul_sel;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic [DATA_WIDTH-1:0] raw_res;

    // Unit-side fix-up: half select, sign restore, W sign-extension
    always_comb begin
        mul_sel    = (op_func3 == F3_MUL) ? mul_result[DATA_WIDTH-1:0]
                                          : mul_result[2*DATA_WIDTH-1:DATA_WIDTH];
        quo_fix    = op_neg_q ? -div_quo : div_quo;
        rem_fix    = op_neg_r ? -div_rem : div_rem;
        raw_res    = op_func3[2] ? (op_func3[1] ? rem_fix : quo_fix) : mul_sel;
        fix_data_c = op_word ? sext_half(raw_res) : raw_res;
    end

endmodule

// File: rtl/ysyx_040729_exe_mdu_ctrl.sv
// Sequencer between EXE and the shared iterative multiplier/divider.
module ysyx_040729_exe_mdu_ctrl
    import ysyx_040729_exe_mdu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_func3,
    input  logic                    req_word,
    input  logic [DATA_WIDTH-1:0]   req_src1,
    input  logic [DATA_WIDTH-1:0]   req_src2,
    input  logic                    flush,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [DATA_WIDTH-1:0]   unit_a,
    output logic [DATA_WIDTH-1:0]   unit_b,
    output logic                    unit_word,
    output logic                    unit_flush,
    output logic                    mul_valid,
    output logic [1:0]              mul_signed,
    input  logic                    mul_ready,
    input  logic                    mul_out_valid,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    output logic                    div_valid,
    input  logic                    div_ready,
    input  logic                    div_out_valid,
    input  logic [DATA_WIDTH-1:0]   div_quo,
    input  logic [DATA_WIDTH-1:0]   div_rem
);

    mdu_state_e state_q;
    mdu_state_e state_d;

    logic [2:0]            func3_q;
    logic                  word_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic [DATA_WIDTH-1:0] prep_a_c;
    logic [DATA_WIDTH-1:0] prep_b_c;
    logic [1:0]            mul_signed_c;
    logic                  neg_q_c;
    logic                  neg_r_c;
    logic                  special_c;
    logic [DATA_WIDTH-1:0] special_data_c;
    logic [DATA_WIDTH-1:0] fix_data_c;
    logic                  accept_c;
    logic                  complete_c;

    ysyx_040729_exe_mdu_fixup #(.DATA_WIDTH(DATA_WIDTH)) u_fixup (
        .req_func3      (req_func3),
        .req_word       (req_word),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .prep_a_c       (prep_a_c),
        .prep_b_c       (prep_b_c),
        .mul_signed_c   (mul_signed_c),
        .neg_q_c        (neg_q_c),
        .neg_r_c        (neg_r_c),
        .special_c      (special_c),
        .special_data_c (special_data_c),
        .op_func3       (func3_q),
        .op_word        (word_q),
        .op_neg_q       (neg_q_q),
        .op_neg_r       (neg_r_q),
        .mul_result     (mul_result),
        .div_quo        (div_quo),
        .div_rem        (div_rem),
        .fix_data_c     (fix_data_c)
    );

    assign accept_c   = req_valid && req_ready;
    assign complete_c = !flush && (((state_q == ST_MUL_WAIT) && mul_out_valid) ||
                                   ((state_q == ST_DIV_WAIT) && div_out_valid));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_func3[2])  state_d = ST_MUL_ISSUE;
                    else if (special_c) state_d = ST_DONE;
                    else                state_d = ST_DIV_ISSUE;
                end
            end
            ST_MUL_ISSUE: if (mul_ready)     state_d = ST_MUL_WAIT;
            ST_MUL_WAIT:  if (mul_out_valid) state_d = ST_DONE;
            ST_DIV_ISSUE: if (div_ready)     state_d = ST_DIV_WAIT;
            ST_DIV_WAIT:  if (div_out_valid) state_d = ST_DONE;
            ST_DONE:      if (resp_ready)    state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Handshake outputs decoded from state, suppressed by flush
    always_comb begin
        req_ready  = 1'b0;
        mul_valid  = 1'b0;
        div_valid  = 1'b0;
        resp_valid = 1'b0;
        unit_flush = 1'b0;
        unique case (state_q)
            ST_IDLE:      req_ready = !flush;
            ST_MUL_ISSUE: begin
                mul_valid  = !flush;
                unit_flush = flush;
            end
            ST_MUL_WAIT:  unit_flush = flush;
            ST_DIV_ISSUE: begin
                div_valid  = !flush;
                unit_flush = flush;
            end
            ST_DIV_WAIT:  unit_flush = flush;
            ST_DONE:      resp_valid = !flush;
            default:      req_ready = 1'b0;
        endcase
    end

    // Operand latch at accept and result capture at completion
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            func3_q    <= 3'd0;
            word_q     <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_word  <= 1'b0;
            mul_signed <= 2'b00;
            resp_data  <= '0;
        end else if (accept_c) begin
            func3_q    <= req_func3;
            word_q     <= req_word;
            neg_q_q    <= neg_q_c;
            neg_r_q    <= neg_r_c;
            unit_a     <= prep_a_c;
            unit_b     <= prep_b_c;
            unit_word  <= req_word;
            mul_signed <= mul_signed_c;
            if (special_c) begin
                resp_data <= special_data_c;
            end
        end else if (complete_c) begin
            resp_data <= fix_data_c;
        end
    end

endmodule

// File: tb/tb_ysyx_040729_exe_mdu_ctrl.sv
// Directed bench for the multiply/divide sequencer; the bench plays both units.
module tb_ysyx_040729_exe_mdu_ctrl;

    localparam int unsigned DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_func3;
    logic          req_word;
    logic [DW-1:0] req_src1;
    logic [DW-1:0] req_src2;
    logic          flush;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [DW-1:0] unit_a;
    logic [DW-1:0] unit_b;
    logic          unit_word;
    logic          unit_flush;
    logic          mul_valid;
    logic [1:0]    mul_signed;
    logic          mul_ready;
    logic          mul_out_valid;
    logic [2*DW-1:0] mul_result;
    logic          div_valid;
    logic          div_ready;
    logic          div_out_valid;
    logic [DW-1:0] div_quo;
    logic [DW-1:0] div_rem;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_040729_exe_mdu_ctrl #(.DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_func3     (req_func3),
        .req_word      (req_word),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .unit_a        (unit_a),
        .unit_b        (unit_b),
        .unit_word     (unit_word),
        .unit_flush    (unit_flush),
        .mul_valid     (mul_valid),
        .mul_signed    (mul_signed),
        .mul_ready     (mul_ready),
        .mul_out_valid (mul_out_valid),
        .mul_result    (mul_result),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_out_valid (div_out_valid),
        .div_quo       (div_quo),
        .div_rem       (div_rem)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present one request for a single cycle; returns at the negedge after accept
    task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1;
        req_func3 = f3;
        req_word  = w;
        req_src1  = a;
        req_src2  = b;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        check({tag, "_after_take_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_after_take_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_func3 = 3'd0; req_word = 1'b0;
        req_src1 = '0; req_src2 = '0; flush = 1'b0; resp_ready = 1'b0;
        mul_ready = 1'b1; mul_out_valid = 1'b0; mul_result = '0;
        div_ready = 1'b1; div_out_valid = 1'b0; div_quo = '0; div_rem = '0;
        repeat (2) @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_unit_a", unit_a, 64'd0);
        check("rst_mul_valid", 64'(mul_valid), 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        reset = 1'b0;
        cyc();

        // mul 3 * -5
        send(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        check("mul_valid_issue", 64'(mul_valid), 64'd1);
        check("mul_signed_mul", 64'(mul_signed), 64'd3);
        check("mul_unit_a", unit_a, 64'd3);
        check("mul_unit_b", unit_b, 64'hFFFF_FFFF_FFFF_FFFB);
        check("mul_req_ready_busy", 64'(req_ready), 64'd0);
        cyc();
        check("mul_valid_wait", 64'(mul_valid), 64'd0);
        mul_result = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1};
        mul_out_valid = 1'b1;
        cyc();
        mul_out_valid = 1'b0;
        check("mul_resp_valid", 64'(resp_valid), 64'd1);
        check("mul_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF1);
        take("mul");

        // mulhsu -1 * 5 takes the high half
        send(3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        check("mulhsu_signed", 64'(mul_signed), 64'd2);
        cyc();
        mul_result = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
        mul_out_valid = 1'b1;
        cyc();
        mul_out_valid = 1'b0;
        check("mulhsu_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        take("mulhsu");

        // mulw 0x7FFFFFFF * 2 with garbage upper bits
        send(3'b000, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002);
        check("mulw_unit_a", unit_a, 64'h0000_0000_7FFF_FFFF);
        check("mulw_unit_b", unit_b, 64'd2);
        check("mulw_unit_word", 64'(unit_word), 64'd1);
        cyc();
        mul_result = {64'd0, 64'h0000_0000_FFFF_FFFE};
        mul_out_valid = 1'b1;
        cyc();
        mul_out_valid = 1'b0;
        check("mulw_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
        take("mulw");

        // div 7/0 short-circuit
        send(3'b100, 1'b0, 64'd7, 64'd0);
        check("div0_resp_valid", 64'(resp_valid), 64'd1);
        check("div0_div_valid", 64'(div_valid), 64'd0);
        check("div0_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        take("div0");

        // rem 7/0 short-circuit
        send(3'b110, 1'b0, 64'd7, 64'd0);
        check("rem0_resp_valid", 64'(resp_valid), 64'd1);
        check("rem0_resp_data", resp_data, 64'd7);
        take("rem0");

        // remuw with zero low-word divisor: remainder is zext dividend, then sext
        send(3'b111, 1'b1, 64'h0000_0001_8000_0000, 64'hABCD_0000_0000_0000);
        check("remuw0_div_valid", 64'(div_valid), 64'd0);
        check("remuw0_resp_data", resp_data, 64'hFFFF_FFFF_8000_0000);
        take("remuw0");

        // divw overflow
        send(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check("divw_ovf_resp_valid", 64'(resp_valid), 64'd1);
        check("divw_ovf_div_valid", 64'(div_valid), 64'd0);
        check("divw_ovf_resp_data", resp_data, 64'hFFFF_FFFF_8000_0000);
        take("divw_ovf");

        // rem 64-bit overflow -> 0
        send(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rem_ovf_resp_data", resp_data, 64'd0);
        take("rem_ovf");

        // rem -7 % 2 with divider busy for two cycles
        div_ready = 1'b0;
        send(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        check("rem_div_valid_issue", 64'(div_valid), 64'd1);
        check("rem_unit_a", unit_a, 64'd7);
        check("rem_unit_b", unit_b, 64'd2);
        cyc();
        check("rem_div_valid_held", 64'(div_valid), 64'd1);
        div_ready = 1'b1;
        cyc();
        check("rem_div_valid_wait", 64'(div_valid), 64'd0);
        div_quo = 64'd3; div_rem = 64'd1; div_out_valid = 1'b1;
        cyc();
        div_out_valid = 1'b0;
        check("rem_resp_valid", 64'(resp_valid), 64'd1);
        check("rem_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // hold in DONE for 3 cycles; stray completion pulses are ignored
        for (int i = 0; i < 3; i++) begin
            div_rem = 64'd5;
            div_out_valid = (i == 0);
            mul_out_valid = (i == 1);
            cyc();
            div_out_valid = 1'b0;
            mul_out_valid = 1'b0;
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        take("rem");

        // div -100 / 7 = -14
        send(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        check("div_unit_a", unit_a, 64'd100);
        check("div_unit_b", unit_b, 64'd7);
        cyc();
        div_quo = 64'd14; div_rem = 64'd2; div_out_valid = 1'b1;
        cyc();
        div_out_valid = 1'b0;
        check("div_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF2);
        take("div");

        // flush in MUL_WAIT followed by a late completion
        send(3'b011, 1'b0, 64'd5, 64'd6);
        check("mulhu_signed", 64'(mul_signed), 64'd0);
        cyc();
        flush = 1'b1;
        #1;
        check("flush_unit_flush", 64'(unit_flush), 64'd1);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        check("flush_unit_flush_end", 64'(unit_flush), 64'd0);
        check("flush_idle_req_ready", 64'(req_ready), 64'd1);
        cyc();
        mul_result = {64'd0, 64'd30};
        mul_out_valid = 1'b1;
        cyc();
        mul_out_valid = 1'b0;
        check("flush_late_resp_valid", 64'(resp_valid), 64'd0);
        check("flush_late_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF2);

        // flush in IDLE blocks acceptance
        req_valid = 1'b1; req_func3 = 3'b000; req_word = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_idle_block_ready", 64'(req_ready), 64'd0);
        check("flush_idle_no_unit_flush", 64'(unit_flush), 64'd0);
        cyc();
        req_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_no_issue", 64'(mul_valid), 64'd0);

        // async reset in DIV_WAIT
        send(3'b101, 1'b0, 64'd100, 64'd7);
        check("divu_unit_a", unit_a, 64'd100);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("arst_unit_a", unit_a, 64'd0);
        check("arst_unit_b", unit_b, 64'd0);
        check("arst_resp_data", resp_data, 64'd0);
        check("arst_div_valid", 64'(div_valid), 64'd0);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("arst_release_req_ready", 64'(req_ready), 64'd1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
